axi4_mem_responder: RTL
=======================

// Module: axi4_mem_responder
// PURPOSE
//  Synthesizable AXI4 subordinate backed by a byte-addressed memory; the responding end of the bus checked by the AXI4 SVA monitor.
//  Accepts AW/W/AR, returns B/R with stable payload under backpressure, so the assertion set can be exercised in closed loop.
//  One write and one read burst in flight; the write and read paths run concurrently.
// PARAMETERS
//  ADDR_W     32    address width
//  DATA_W     64    data width; STRB_W = DATA_W/8
//  ID_W       4     ID width; BID/RID echo the request ID
//  USER_W     1     user width; BUSER/RUSER driven 0
//  MEM_BYTES  4096  memory size; power of 2; index = addr % MEM_BYTES
// PORTS
//  aclk      in   1  clock, all logic on posedge
//  areset_n  in   1  async active-low reset
//  aw*       in   -  awvalid, awid[ID_W], awaddr[ADDR_W], awlen[8], awsize[3], awburst[2]; lock/cache/prot/qos/region/user ignored
//  awready   out  1  write address accept
//  w*        in   -  wvalid, wdata[DATA_W], wstrb[STRB_W], wlast; wuser ignored
//  wready    out  1  write data accept
//  b*        out  -  bvalid, bid[ID_W], bresp[2], buser[USER_W]; bready in
//  ar*       in   -  arvalid, arid, araddr, arlen, arsize, arburst; others ignored
//  arready   out  1  read address accept
//  r*        out  -  rvalid, rid[ID_W], rdata[DATA_W], rresp[2], rlast, ruser[USER_W]; rready in
// BEHAVIOUR
//  Reset: all FSMs to IDLE; awready=arready=1; wready=bvalid=rvalid=rlast=0; bresp/rresp=OKAY; IDs/rdata=0.
//   Memory is not cleared. Reset mid-burst abandons the burst.
//  Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE
//   W_IDLE: awready=1; on awvalid capture id/addr/len/size/burst, beat=0, go W_DATA.
//   W_DATA: wready=1; each handshake writes byte lane i to mem[(addr & ~(STRB_W-1)) + i] where wstrb[i]=1.
//    Burst ends at beat==len OR wlast, whichever comes first; go W_RESP next cycle.
//   W_RESP: bvalid=1, bid=captured id; hold until bready; then W_IDLE (awready back next cycle).
//  Read FSM R_IDLE->R_DATA->R_IDLE
//   R_IDLE: arready=1; on arvalid capture the request; rvalid asserts next cycle (latency 1).
//   R_DATA: rdata = bus-aligned word at the current address; rlast=(beat==len).
//    Payload is registered and held stable while rvalid&&!rready.
//    On handshake: advance address, load next beat in same edge (no bubble); after rlast, go R_IDLE.
//  Address update (sub-module): sz=1<<size; aligned=addr&~(sz-1).
//   FIXED: unchanged. INCR: aligned+sz.
//   WRAP: wb=sz*(len+1); lo=addr&~(wb-1); next=lo+((aligned+sz-lo)%wb).
//  Error rules -> SLVERR (bresp once; rresp on every beat); transfer still completes normally:
//   sz>STRB_W; burst==2'b11 (treated as INCR); WRAP with len not in {1,3,7,15} (treated as INCR);
//   write only: wlast mismatch with beat count (early or missing).
//  Simultaneous read/write to same byte in one cycle: read returns old data (read-before-write).
//  Index wraps modulo MEM_BYTES; no DECERR.
// STRUCTURE
//  axi4_pkg: axi4_burst_e {FIXED,INCR,WRAP}, AXI4_RESP_OKAY=2'b00, AXI4_RESP_SLVERR=2'b10, wr_state_e, rd_state_e.
//  Sub-module axi4_burst_addr (combinational next-address + legality flag), instantiated once per FSM.
// TESTING
//  INCR write awaddr=0x10,len=3,size=3,strb=FF, then read -> 4 beats echo data, rlast on beat 4, OKAY, rid=awid.
//  WRAP read araddr=0x38,len=3,size=3 -> beat addresses 0x38,0x20,0x28,0x30.
//  rready low 5 cycles mid-burst -> rvalid/rdata/rlast/rid stable; no beat lost or duplicated.
//  Write len=3 with wlast on beat 2 -> burst ends, bresp=SLVERR; next AW accepted after bready.
//  awsize=4 on DATA_W=64, and awburst=3 -> SLVERR; data still written per strobe.
//  areset_n low mid read burst -> rvalid=0 async, arready=1 after release; new AR served correctly.

Source files
------------

// File: rtl/axi4_mem_responder_pkg.sv
// Shared types for the AXI4 memory responder: burst encodings, response
// codes and the write/read FSM state enums.
package axi4_mem_responder_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi4_burst_e;

    localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axi4_mem_responder_if.sv
// AXI4 channel bundle used between a manager and the memory responder.
// Only the fields the responder acts on are carried.
interface axi4_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int USER_W = 1
);
    localparam int STRB_W = DATA_W / 8;

    logic              awvalid, awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic              wvalid, wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;

    logic              bvalid, bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic [USER_W-1:0] buser;

    logic              arvalid, arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid, rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [USER_W-1:0] ruser;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bid, bresp, buser,
        input  arready, rvalid, rid, rdata, rresp, rlast, ruser
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bid, bresp, buser,
        output arready, rvalid, rid, rdata, rresp, rlast, ruser
    );

endinterface

// File: rtl/axi4_mem_responder_burst_addr.sv
// Combinational AXI4 next-beat address and request legality check.
// Illegal burst types and illegal WRAP lengths advance as INCR.
module axi4_burst_addr
    import axi4_mem_responder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int STRB_W = 8
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              err_o
);
    logic [ADDR_W-1:0] sz, aligned, lenp1, wb, lo;
    logic              wrap_len_ok;

    // Next address per burst type; wrap boundary is a power of two for legal lengths
    always_comb begin
        sz          = ADDR_W'(1) << size_i;
        aligned     = addr_i & ~(sz - ADDR_W'(1));
        lenp1       = ADDR_W'(len_i) + ADDR_W'(1);
        wb          = sz * lenp1;
        lo          = addr_i & ~(wb - ADDR_W'(1));
        wrap_len_ok = len_i inside {8'd1, 8'd3, 8'd7, 8'd15};
        err_o       = (sz > ADDR_W'(STRB_W)) || (burst_i == 2'b11) ||
                      ((burst_i == BURST_WRAP) && !wrap_len_ok);
        if (burst_i == BURST_FIXED)
            next_addr_o = addr_i;
        else if ((burst_i == BURST_WRAP) && wrap_len_ok)
            next_addr_o = lo + ((aligned + sz - lo) & (wb - ADDR_W'(1)));
        else
            next_addr_o = aligned + sz;
    end

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 subordinate backed by a byte-addressed memory. One write burst and
// one read burst may be in flight at once; the two paths are independent.
module axi4_mem_responder
    import axi4_mem_responder_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int USER_W    = 1,
    parameter int MEM_BYTES = 4096
) (
    input  logic                aclk,
    input  logic                areset_n,
    axi4_mem_responder_if.slave bus
);
    localparam int                STRB_W    = DATA_W / 8;
    localparam int                IDX_W     = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(STRB_W - 1);

    logic [7:0] mem_q [MEM_BYTES];

    // ---------------- write path ----------------
    wr_state_e         wr_state_q, wr_state_d;
    logic [ID_W-1:0]   wid_q;
    logic [ADDR_W-1:0] waddr_q, wnext_addr, wbase;
    logic [7:0]        wlen_q, wbeat_q;
    logic [2:0]        wsize_q;
    logic [1:0]        wburst_q;
    logic              wlast_err_q, wreq_err;
    logic              aw_hs, w_hs, w_last_bad;

    axi4_burst_addr #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) u_wr_addr (
        .addr_i(waddr_q), .len_i(wlen_q), .size_i(wsize_q), .burst_i(wburst_q),
        .next_addr_o(wnext_addr), .err_o(wreq_err)
    );

    assign aw_hs      = bus.awvalid && bus.awready;
    assign w_hs       = bus.wvalid && bus.wready;
    // wlast must coincide exactly with the final counted beat
    assign w_last_bad = bus.wlast != (wbeat_q == wlen_q);
    assign wbase      = waddr_q & ~LANE_MASK;
    assign bus.bid    = wid_q;
    assign bus.bresp  = (wreq_err || wlast_err_q) ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY;
    assign bus.buser  = '0;

    // Write FSM state register
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) wr_state_q <= W_IDLE;
        else           wr_state_q <= wr_state_d;
    end

    // Write FSM next state and channel handshakes; burst ends on len or wlast
    always_comb begin
        wr_state_d  = wr_state_q;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                bus.awready = 1'b1;
                if (bus.awvalid) wr_state_d = W_DATA;
            end
            W_DATA: begin
                bus.wready = 1'b1;
                if (bus.wvalid && ((wbeat_q == wlen_q) || bus.wlast)) wr_state_d = W_RESP;
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write request capture and per-beat address/count/error tracking
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wid_q       <= '0;
            waddr_q     <= '0;
            wlen_q      <= '0;
            wbeat_q     <= '0;
            wsize_q     <= '0;
            wburst_q    <= '0;
            wlast_err_q <= 1'b0;
        end else if (aw_hs) begin
            wid_q       <= bus.awid;
            waddr_q     <= bus.awaddr;
            wlen_q      <= bus.awlen;
            wbeat_q     <= '0;
            wsize_q     <= bus.awsize;
            wburst_q    <= bus.awburst;
            wlast_err_q <= 1'b0;
        end else if (w_hs) begin
            waddr_q     <= wnext_addr;
            wbeat_q     <= wbeat_q + 8'd1;
            wlast_err_q <= wlast_err_q | w_last_bad;
        end
    end

    // Byte-lane writes into the bus-aligned word; memory contents survive reset
    always_ff @(posedge aclk) begin
        if (w_hs) begin
            for (int i = 0; i < STRB_W; i++)
                if (bus.wstrb[i]) mem_q[IDX_W'(wbase + ADDR_W'(i))] <= bus.wdata[8*i +: 8];
        end
    end

    // ---------------- read path ----------------
    rd_state_e         rd_state_q, rd_state_d;
    logic [ID_W-1:0]   rid_q;
    logic [ADDR_W-1:0] raddr_q, rnext_addr, rba_addr, rd_fetch_addr, rd_base;
    logic [7:0]        rlen_q, rbeat_q, rba_len;
    logic [2:0]        rsize_q, rba_size;
    logic [1:0]        rburst_q, rba_burst, rresp_q;
    logic [DATA_W-1:0] rdata_q, rd_word;
    logic              rlast_q, rreq_err, ar_hs, r_hs;

    // While idle the checker looks at the incoming AR so the response code is known at capture
    assign rba_addr  = (rd_state_q == R_IDLE) ? bus.araddr  : raddr_q;
    assign rba_len   = (rd_state_q == R_IDLE) ? bus.arlen   : rlen_q;
    assign rba_size  = (rd_state_q == R_IDLE) ? bus.arsize  : rsize_q;
    assign rba_burst = (rd_state_q == R_IDLE) ? bus.arburst : rburst_q;

    axi4_burst_addr #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) u_rd_addr (
        .addr_i(rba_addr), .len_i(rba_len), .size_i(rba_size), .burst_i(rba_burst),
        .next_addr_o(rnext_addr), .err_o(rreq_err)
    );

    assign ar_hs         = bus.arvalid && bus.arready;
    assign r_hs          = bus.rvalid && bus.rready;
    assign rd_fetch_addr = ar_hs ? bus.araddr : rnext_addr;
    assign bus.rid       = rid_q;
    assign bus.rdata     = rdata_q;
    assign bus.rresp     = rresp_q;
    assign bus.rlast     = rlast_q;
    assign bus.ruser     = '0;

    // Memory word for the beat that will be presented after this edge
    always_comb begin
        rd_word = '0;
        rd_base = rd_fetch_addr & ~LANE_MASK;
        for (int i = 0; i < STRB_W; i++)
            rd_word[8*i +: 8] = mem_q[IDX_W'(rd_base + ADDR_W'(i))];
    end

    // Read FSM state register
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) rd_state_q <= R_IDLE;
        else           rd_state_q <= rd_state_d;
    end

    // Read FSM next state; leaves R_DATA only once the last beat is taken
    always_comb begin
        rd_state_d  = rd_state_q;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                bus.arready = 1'b1;
                if (bus.arvalid) rd_state_d = R_DATA;
            end
            R_DATA: begin
                bus.rvalid = 1'b1;
                if (bus.rready && rlast_q) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Registered read payload: loads on AR and on each non-final handshake, else holds
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rbeat_q  <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
            rresp_q  <= AXI4_RESP_OKAY;
        end else if (ar_hs) begin
            rid_q    <= bus.arid;
            raddr_q  <= bus.araddr;
            rlen_q   <= bus.arlen;
            rbeat_q  <= '0;
            rsize_q  <= bus.arsize;
            rburst_q <= bus.arburst;
            rdata_q  <= rd_word;
            rlast_q  <= (bus.arlen == 8'd0);
            rresp_q  <= rreq_err ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY;
        end else if (r_hs && !rlast_q) begin
            raddr_q  <= rnext_addr;
            rbeat_q  <= rbeat_q + 8'd1;
            rdata_q  <= rd_word;
            rlast_q  <= ((rbeat_q + 8'd1) == rlen_q);
        end else if (r_hs) begin
            rlast_q  <= 1'b0;
        end
    end

endmodule
